// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response and ALU-side bus of the two-port ALU arbiter.
// slave modport is the arbiter view; master modport is the requester/ALU view.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    // requester side, port i on bits [8i+7:8i]
    logic [1:0]              req_valid_in;
    logic [1:0]              req_ready_out;
    logic [2*DATA_WIDTH-1:0] req_opcode_in;
    logic [2*DATA_WIDTH-1:0] req_a_in;
    logic [2*DATA_WIDTH-1:0] req_b_in;
    logic [1:0]              resp_valid_out;
    logic [1:0]              resp_ready_in;
    logic [DATA_WIDTH-1:0]   resp_data_out;
    logic [4:0]              resp_flags_out;
    // ALU side
    logic                    alu_reset_out;
    logic                    alu_enable_out;
    logic [DATA_WIDTH-1:0]   alu_opcode_out;
    logic [DATA_WIDTH-1:0]   alu_input1_out;
    logic [DATA_WIDTH-1:0]   alu_input2_out;
    logic [DATA_WIDTH-1:0]   alu_output_in;
    logic [4:0]              alu_flags_in;
    // status
    logic                    busy_out;

    modport slave (
        input  req_valid_in, req_opcode_in, req_a_in, req_b_in, resp_ready_in,
        input  alu_output_in, alu_flags_in,
        output req_ready_out, resp_valid_out, resp_data_out, resp_flags_out,
        output alu_reset_out, alu_enable_out, alu_opcode_out, alu_input1_out,
        output alu_input2_out, busy_out
    );

    modport master (
        output req_valid_in, req_opcode_in, req_a_in, req_b_in, resp_ready_in,
        output alu_output_in, alu_flags_in,
        input  req_ready_out, resp_valid_out, resp_data_out, resp_flags_out,
        input  alu_reset_out, alu_enable_out, alu_opcode_out, alu_input1_out,
        input  alu_input2_out, busy_out
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Flow per transaction: IDLE (accept + latch) -> ISSUE (one ALU cycle,
// result captured) -> RESP (held until the granted port takes it).
// Build option ALU_ARBITER_RR_EN: round-robin arbitration between the two
// ports; without it port 0 has fixed priority and no pointer is built.
// DATA_WIDTH must be 8 and must match the interface instance parameter.
module alu_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          clock_in,
    input  logic          reset_in,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [1:0][DATA_WIDTH-1:0] op_port;
    logic [1:0][DATA_WIDTH-1:0] a_port;
    logic [1:0][DATA_WIDTH-1:0] b_port;

    logic                   win;       // arbitration winner in IDLE
    logic                   accept;    // a request is taken this cycle
    logic                   gnt_q;     // port owning the in-flight transaction
    logic [DATA_WIDTH-1:0]  op_q;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  b_q;
    logic [DATA_WIDTH-1:0]  res_q;
    logic [4:0]             flags_q;

    logic [1:0]             req_ready;
    logic [1:0]             resp_valid;
    logic                   alu_enable;

    // split the packed request buses into per-port fields
    for (genvar i = 0; i < 2; i++) begin : g_port
        assign op_port[i] = bus.req_opcode_in[DATA_WIDTH*i +: DATA_WIDTH];
        assign a_port[i]  = bus.req_a_in[DATA_WIDTH*i +: DATA_WIDTH];
        assign b_port[i]  = bus.req_b_in[DATA_WIDTH*i +: DATA_WIDTH];
    end

`ifdef ALU_ARBITER_RR_EN
    logic ptr_q;   // port favoured when both request

    // pointer flips away from whichever port was just accepted
    always_ff @(posedge clock_in) begin
        if (reset_in)
            ptr_q <= 1'b0;
        else if (accept)
            ptr_q <= ~win;
    end

    // round-robin pick: pointer breaks ties, otherwise the lone requester wins
    always_comb begin
        win = 1'b0;
        if (&bus.req_valid_in)
            win = ptr_q;
        else if (bus.req_valid_in[1])
            win = 1'b1;
    end
`else
    // fixed priority: port 1 only wins when port 0 is not requesting
    always_comb begin
        win = ~bus.req_valid_in[0] & bus.req_valid_in[1];
    end
`endif

    // state register
    always_ff @(posedge clock_in) begin
        if (reset_in)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state and handshake outputs; reset masks every strobe so an
    // aborted transaction never shows a grant, an ALU enable or a response
    always_comb begin
        state_nxt  = state;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        alu_enable = 1'b0;
        case (state)
            IDLE: begin
                if (!reset_in && (|bus.req_valid_in)) begin
                    req_ready[win] = 1'b1;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                alu_enable = ~reset_in;
                state_nxt  = RESP;
            end
            RESP: begin
                resp_valid[gnt_q] = ~reset_in;
                if (bus.resp_ready_in[gnt_q])
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = |req_ready;

    // capture the winner's opcode/operands and remember who owns the result
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            gnt_q <= 1'b0;
        end else if (accept) begin
            op_q  <= op_port[win];
            a_q   <= a_port[win];
            b_q   <= b_port[win];
            gnt_q <= win;
        end
    end

    // the ALU is combinational, so its output is valid by the end of ISSUE
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            res_q   <= '0;
            flags_q <= '0;
        end else if (state == ISSUE) begin
            res_q   <= bus.alu_output_in;
            flags_q <= bus.alu_flags_in;
        end
    end

    assign bus.req_ready_out  = req_ready;
    assign bus.resp_valid_out = resp_valid;
    assign bus.resp_data_out  = res_q;
    assign bus.resp_flags_out = flags_q;
    assign bus.alu_reset_out  = reset_in;
    assign bus.alu_enable_out = alu_enable;
    assign bus.alu_opcode_out = op_q;
    assign bus.alu_input1_out = a_q;
    assign bus.alu_input2_out = b_q;
    assign bus.busy_out       = (state != IDLE);

endmodule
